// File: rtl/tx_pkg.sv
// tx_pkg: shared constants for the transmitter AM path.
//   AM_DATA_W / AM_FIFO_DEPTH : default envelope width and pacer FIFO depth
//   CLK_HZ / AM_SAMPLE_HZ     : system clock and envelope sample rate
//   AM_DIVIDE                 : clocks per envelope sample
//   STREAM_W                  : width of controller stream words
package tx_pkg;
  localparam int STREAM_W      = 32;
  localparam int AM_DATA_W     = 16;
  localparam int AM_FIFO_DEPTH = 16;
  localparam int CLK_HZ        = 100_000_000;
  localparam int AM_SAMPLE_HZ  = 40_000;
  localparam int AM_DIVIDE     = CLK_HZ / AM_SAMPLE_HZ;
endpackage

// File: rtl/tx_am_pacer_fifo.sv
// am_fifo: synchronous FIFO holding queued envelope samples.
//   clk, rst    : clock, synchronous active-high reset (pointers and count)
//   push, din   : write din at the tail (ignored when full)
//   pop, dout   : dout is the current head; pop advances it (ignored when empty)
//   full, empty : occupancy flags
//   fill        : occupancy, 0..DEPTH, from a dedicated up/down counter
module am_fifo
  import tx_pkg::*;
#(
  parameter int WIDTH = AM_DATA_W,
  parameter int DEPTH = AM_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              do_push, do_pop;

  assign full    = (fill_q == FILL_W'(DEPTH));
  assign empty   = (fill_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign fill    = fill_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      fill_d = fill_q + 1'b1;
    end else if (do_pop && !do_push) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/tx_am_pacer.sv
// tx_am_pacer: rate-matches the controller's AM word stream to a fixed
// envelope sample rate, holding the last level on underflow.
//   clk, rst            : clock, synchronous active-high reset
//   input_tx_am[_stb]   : amplitude word and valid (low DATA_W bits used)
//   input_tx_am_ack     : ready; transfer on stb && ack
//   enable              : pacing enable; low forces level 0 and stops draining
//   am_level            : registered envelope level
//   am_valid            : one-cycle pulse per sample tick
//   underflow           : one-cycle pulse on a tick that found the FIFO empty
//   underflow_count     : saturating count of underflow ticks
//   fill                : FIFO occupancy
module tx_am_pacer
  import tx_pkg::*;
#(
  parameter int DATA_W = AM_DATA_W,
  parameter int DEPTH  = AM_FIFO_DEPTH,
  parameter int DIVIDE = AM_DIVIDE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STREAM_W-1:0]    input_tx_am,
  input  logic                   input_tx_am_stb,
  output logic                   input_tx_am_ack,
  input  logic                   enable,
  output logic [DATA_W-1:0]      am_level,
  output logic                   am_valid,
  output logic                   underflow,
  output logic [15:0]            underflow_count,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int              CNT_W    = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);

  logic              rst_q, rst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] am_level_q, am_level_d;
  logic              am_valid_q, am_valid_d;
  logic              underflow_q, underflow_d;
  logic [15:0]       uf_count_q, uf_count_d;

  logic              tick, push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;
  logic [STREAM_W-1:0] unused_word;

  assign unused_word     = input_tx_am;
  // rst_q keeps ack low for one cycle after reset is released.
  assign input_tx_am_ack = !rst_q && !fifo_full;
  assign push            = input_tx_am_stb && input_tx_am_ack;
  assign tick            = enable && (cnt_q == CNT_LAST);
  // Pop decision uses registered occupancy, so a word pushed on a tick
  // cycle cannot satisfy that same tick.
  assign pop             = tick && !fifo_empty;

  am_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (input_tx_am[DATA_W-1:0]),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  always_comb begin
    rst_d       = rst;
    cnt_d       = '0;
    am_level_d  = am_level_q;
    am_valid_d  = tick;
    underflow_d = tick && fifo_empty;
    uf_count_d  = uf_count_q;
    if (enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (pop) begin
      am_level_d = head;
    end
    if (underflow_d && (uf_count_q != 16'hFFFF)) begin
      uf_count_d = uf_count_q + 16'd1;
    end
    if (!enable) begin
      am_level_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst_d;
    if (rst) begin
      cnt_q       <= '0;
      am_level_q  <= '0;
      am_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      uf_count_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      am_level_q  <= am_level_d;
      am_valid_q  <= am_valid_d;
      underflow_q <= underflow_d;
      uf_count_q  <= uf_count_d;
    end
  end

  assign am_level        = am_level_q;
  assign am_valid        = am_valid_q;
  assign underflow       = underflow_q;
  assign underflow_count = uf_count_q;
endmodule

// File: tb/tb_tx_am_pacer.sv
module tb_tx_am_pacer;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int DV = 4;
  localparam int FW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   din = '0;
  logic          ack, am_valid, underflow;
  logic [DW-1:0] am_level;
  logic [15:0]   ucnt;
  logic [FW-1:0] fill;

  tx_am_pacer #(.DATA_W(DW), .DEPTH(DP), .DIVIDE(DV)) dut (
    .clk             (clk),
    .rst             (rst),
    .input_tx_am     (din),
    .input_tx_am_stb (stb),
    .input_tx_am_ack (ack),
    .enable          (enable),
    .am_level        (am_level),
    .am_valid        (am_valid),
    .underflow       (underflow),
    .underflow_count (ucnt),
    .fill            (fill)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending words plus the count of consecutive
  // enabled cycles; a sample is due on every DV-th enabled cycle.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_level = '0;
  logic          m_valid = 1'b0;
  logic          m_uf = 1'b0;
  logic          m_post = 1'b1;
  logic          m_acc = 1'b0;
  int            m_ucnt = 0;
  int            m_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic ack_pre;
    logic due;
    ack_pre = !m_post && (mq.size() != DP);
    m_acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_level = '0; m_valid = 1'b0; m_uf = 1'b0;
      m_ucnt = 0; m_run = 0; m_post = 1'b1;
    end else begin
      due = enable && ((m_run % DV) == DV - 1);
      m_valid = due;
      m_uf = 1'b0;
      if (due) begin
        if (mq.size() > 0) m_level = mq.pop_front();
        else begin
          m_uf = 1'b1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
      if (!enable) m_level = '0;
      if (stb && ack_pre) begin
        mq.push_back(din[DW-1:0]);
        m_acc = 1'b1;
      end
      m_run = enable ? m_run + 1 : 0;
      m_post = 1'b0;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("am_level", 32'(am_level), 32'(m_level));
    chk("am_valid", 32'(am_valid), 32'(m_valid));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("uf_count", 32'(ucnt), m_ucnt);
    chk("fill", 32'(fill), mq.size());
    chk("ack", 32'(ack), 32'(!m_post && (mq.size() != DP)));
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    stb = 1'b1;
    din = w;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_acc && n < 40);
    chk("push_timeout", 32'(n < 40), 32'd1);
    stb = 1'b0;
  endtask

  initial begin
    int n, got, uf;
    int times[$];
    logic [DW-1:0] vals[$];
    logic ab;

    // Reset and post-reset ack hold-off
    cyc(); cyc();
    rst = 1'b0;
    chk("ack_post_reset", 32'(ack), 32'd0);
    cyc();

    // Three back-to-back words, ticks every DV cycles
    enable = 1'b1;
    push_word(32'h0010); push_word(32'h0020); push_word(32'h0030);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (am_valid && !underflow) begin
        vals.push_back(am_level);
        times.push_back(i);
      end
    end
    chk("burst_count", vals.size(), 3);
    if (vals.size() == 3) begin
      chk("burst_v0", 32'(vals[0]), 32'h10);
      chk("burst_v1", 32'(vals[1]), 32'h20);
      chk("burst_v2", 32'(vals[2]), 32'h30);
      chk("burst_gap0", times[1] - times[0], DV);
      chk("burst_gap1", times[2] - times[1], DV);
    end

    // Full FIFO backpressure
    enable = 1'b0;
    cyc();
    chk("level_zero_disabled", 32'(am_level), 32'd0);
    push_word(32'h41); push_word(32'h42); push_word(32'h43); push_word(32'h44);
    stb = 1'b1; din = 32'h50;
    cyc(); cyc();
    chk("full_ack", 32'(ack), 32'd0);
    chk("full_fill", 32'(fill), DP);
    enable = 1'b1;
    n = 0;
    do begin
      ab = ack;
      cyc();
      n++;
    end while (!ab && n < 40);
    chk("full_accept_cycle", n, DV + 1);
    stb = 1'b0;
    for (int i = 0; i < 6 * DV; i++) cyc();

    // Underflow holds last level
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    enable = 1'b0;
    push_word(32'h77);
    enable = 1'b1;
    uf = 0;
    for (int i = 0; i < 4 * DV; i++) begin
      cyc();
      if (underflow) uf++;
    end
    chk("uf_pulses", uf, 3);
    chk("uf_hold_level", 32'(am_level), 32'h77);
    chk("uf_count3", 32'(ucnt), 32'd3);

    // Push into empty FIFO on the tick cycle
    n = 0;
    while (((m_run % DV) != DV - 1) && n < 2 * DV) begin
      cyc();
      n++;
    end
    stb = 1'b1; din = 32'h99;
    cyc();
    stb = 1'b0;
    chk("tick_push_uf", 32'(underflow), 32'd1);
    chk("tick_push_fill", 32'(fill), 32'd1);
    for (int i = 0; i < DV; i++) cyc();
    chk("tick_push_out", 32'(am_level), 32'h99);
    chk("tick_push_valid", 32'(am_valid), 32'd1);
    chk("tick_push_nouf", 32'(underflow), 32'd0);

    // Reset mid-stream discards queued words
    enable = 1'b0; cyc();
    push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
    enable = 1'b1; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_level", 32'(am_level), 32'd0);
    chk("rst_ucnt", 32'(ucnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    got = 0;
    for (int i = 0; i < 4 * DV; i++) begin
      cyc();
      if (am_valid && !underflow) got++;
    end
    chk("rst_no_stale", got, 0);

    // Upper input bits are dropped
    push_word(32'hDEAD1234);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(am_valid && !underflow) && n < 3 * DV);
    chk("trunc_level", 32'(am_level), 32'h1234);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (!stb || m_acc) begin
        stb = ($urandom_range(0, 7) < (((i / 150) % 2 == 1) ? 6 : 1));
        din = $urandom;
      end
      if ($urandom_range(0, 59) == 0) enable = !enable;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    stb = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
